// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : handshaked, parametrised successor to the KGP-RISC combinational ALU.
//
// One operation is in flight at a time. Non-multiply operations finish in a
// single cycle. Multiplies run as an iterative shift-add over WIDTH cycles.
// The result is held in output registers until the consumer takes it.
//
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the zero/neg/carry/ovf flags.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request          in_ready   block can accept
//   op_code    operation class (2b)       func_code  operation select (4b)
//   a, b       operands (b also supplies the shift amount in its low SHW bits)
//   out_valid  result available           out_ready  consumer takes result
//   low, high  result low word / high word (carry for add)
//   illegal    result belongs to an unsupported code
//   zero, neg, carry, ovf   status flags (ALU_SEQ_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_code,
  input  logic [3:0]       func_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] low,
  output logic [WIDTH-1:0] high,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
`endif
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  state_t             state;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic               mneg;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic signed [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0]   nxt_low;
  logic [WIDTH-1:0]   nxt_high;
  logic               nxt_ill;
  logic               is_add;
  logic               is_mul;
  logic               is_smul;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_fin;
  logic               accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);

  // Decode and single-cycle datapath, evaluated on the live inputs so the
  // result is captured at the accept edge.
  always_comb begin
    sh       = b[SHW-1:0];
    sum      = {1'b0, a} + {1'b0, b};
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sra_res  = $signed(a) >>> sh;
    nxt_low  = '0;
    nxt_high = '0;
    nxt_ill  = 1'b0;
    is_add   = 1'b0;
    is_mul   = 1'b0;
    is_smul  = 1'b0;
    case (op_code)
      2'b00: begin
        case (func_code)
          4'b0000: begin is_add = 1'b1; nxt_low = sum[WIDTH-1:0]; nxt_high = {{(WIDTH-1){1'b0}}, sum[WIDTH]}; end
          4'b0001: nxt_low = negate_w(b);
          4'b0010: nxt_low = a << sh;
          4'b0011: nxt_low = a >> sh;
          4'b0100: nxt_low = sra_res;
          default: nxt_ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (func_code)
          4'b0000: begin is_add = 1'b1; nxt_low = sum[WIDTH-1:0]; nxt_high = {{(WIDTH-1){1'b0}}, sum[WIDTH]}; end
          4'b0001: is_mul = 1'b1;
          4'b0010: begin is_mul = 1'b1; is_smul = 1'b1; end
          4'b0011: nxt_low = negate_w(b);
          4'b0110: nxt_low = a >> sh;
          4'b0111: nxt_low = a << sh;
          4'b1000: nxt_low = sra_res;
          default: nxt_ill = 1'b1;
        endcase
      end
      default: nxt_ill = 1'b1;
    endcase
    // Magnitudes taken as unsigned WIDTH-bit values, so the most negative
    // operand maps to 2^(WIDTH-1) without overflow.
    a_mag = (is_smul && a[WIDTH-1]) ? negate_w(a) : a;
    b_mag = (is_smul && b[WIDTH-1]) ? negate_w(b) : b;
  end

  assign prod_step = prod + (mplier[0] ? mcand : '0);
  assign prod_fin  = mneg ? negate_2w(prod_step) : prod_step;

  // Multiplier working registers: loaded at accept, stepped once per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      prod   <= '0;
      mneg   <= is_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == MUL) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      low     <= '0;
      high    <= '0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero    <= 1'b0;
      neg     <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              cnt   <= '0;
              state <= MUL;
            end else begin
              low     <= nxt_low;
              high    <= nxt_high;
              illegal <= nxt_ill;
`ifdef ALU_SEQ_FLAGS_EN
              zero    <= (nxt_low == '0);
              neg     <= nxt_low[WIDTH-1];
              carry   <= is_add && sum[WIDTH];
              ovf     <= is_add && add_ovf;
`endif
              state   <= DONE;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == (SHW+1)'(WIDTH-1)) begin
            low     <= prod_fin[WIDTH-1:0];
            high    <= prod_fin[2*WIDTH-1:WIDTH];
            illegal <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero    <= (prod_fin == '0);
            neg     <= prod_fin[2*WIDTH-1];
            carry   <= 1'b0;
            ovf     <= 1'b0;
`endif
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   op_code = '0;
  logic [3:0]   func_code = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         illegal;
  logic [W-1:0] low;
  logic [W-1:0] high;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, neg, carry, ovf;
`endif

  int total = 0;
  int bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .func_code(func_code),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .low(low), .high(high),
`ifdef ALU_SEQ_FLAGS_EN
    .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Presents one request for the accept edge, then scrambles the inputs and
  // counts edges (accept edge = 1) until out_valid, bounded at 200.
  task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output bit rdy_low);
    op_code = op; func_code = fn; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; op_code = 2'b11; func_code = 4'hF;
    lat = 1; rdy_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({in_ready, out_valid, illegal, high, low} !== {3'b100, 64'h0}) begin
      bad++; $display("FAIL reset got rdy=%b vld=%b ill=%b high=%h low=%h want 1 0 0 0 0",
                      in_ready, out_valid, illegal, high, low);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; bit rl;
    issue(2'b00, 4'b0000, 32'h80000002, 32'h80000002, lat, rl);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency got %0d want 1", lat); end
    total++;
    if ({illegal, high, low} !== {1'b0, 32'h1, 32'h4}) begin
      bad++; $display("FAIL add_result got ill=%b high=%h low=%h want 0 00000001 00000004", illegal, high, low);
    end
`ifdef ALU_SEQ_FLAGS_EN
    total++;
    if ({zero, neg, carry, ovf} !== 4'b0011) begin
      bad++; $display("FAIL add_flags got %b want 0011", {zero, neg, carry, ovf});
    end
`endif
    consume();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL add_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    issue(2'b01, 4'b0000, 32'h00000003, 32'hFFFFFFFD, lat, rl);
    total++;
    if ({lat == 1, illegal, high, low} !== {2'b10, 32'h1, 32'h0}) begin
      bad++; $display("FAIL add01_result got lat=%0d ill=%b high=%h low=%h want 1 0 00000001 00000000", lat, illegal, high, low);
    end
`ifdef ALU_SEQ_FLAGS_EN
    total++;
    if ({zero, neg, carry, ovf} !== 4'b1010) begin
      bad++; $display("FAIL add01_flags got %b want 1010", {zero, neg, carry, ovf});
    end
`endif
    consume();
  endtask

  task automatic test_mul_unsigned();
    int lat; bit rl;
    issue(2'b01, 4'b0001, 32'h80000002, 32'h80000002, lat, rl);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL umul_latency got %0d want 33", lat); end
    total++;
    if (rl !== 1'b1) begin bad++; $display("FAIL umul_in_ready got high-during-mul want low"); end
    total++;
    if ({illegal, high, low} !== {1'b0, 32'h40000002, 32'h4}) begin
      bad++; $display("FAIL umul_result got ill=%b high=%h low=%h want 0 40000002 00000004", illegal, high, low);
    end
`ifdef ALU_SEQ_FLAGS_EN
    total++;
    if ({zero, neg, carry, ovf} !== 4'b0000) begin
      bad++; $display("FAIL umul_flags got %b want 0000", {zero, neg, carry, ovf});
    end
`endif
    consume();
  endtask

  task automatic test_mul_signed();
    int lat; bit rl;
    issue(2'b01, 4'b0010, 32'h80000002, 32'h80000002, lat, rl);
    total++;
    if ({lat == 33, illegal, high, low} !== {2'b10, 32'h3FFFFFFE, 32'h4}) begin
      bad++; $display("FAIL smul_pos got lat=%0d ill=%b high=%h low=%h want 33 0 3ffffffe 00000004", lat, illegal, high, low);
    end
    consume();
    issue(2'b01, 4'b0010, 32'h80000000, 32'h00000001, lat, rl);
    total++;
    if ({lat == 33, illegal, high, low} !== {2'b10, 32'hFFFFFFFF, 32'h80000000}) begin
      bad++; $display("FAIL smul_minneg got lat=%0d ill=%b high=%h low=%h want 33 0 ffffffff 80000000", lat, illegal, high, low);
    end
`ifdef ALU_SEQ_FLAGS_EN
    total++;
    if ({zero, neg, carry, ovf} !== 4'b0100) begin
      bad++; $display("FAIL smul_flags got %b want 0100", {zero, neg, carry, ovf});
    end
`endif
    consume();
  endtask

  task automatic test_shifts();
    logic [1:0]   ops [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic [3:0]   fns [6] = '{4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b0110, 4'b1000};
    logic [W-1:0] exp [6] = '{32'h00000008, 32'h20000000, 32'hE0000000,
                              32'h00000008, 32'h20000000, 32'hE0000000};
    int lat; bit rl;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], fns[i], 32'h80000002, 32'h00000022, lat, rl);
      total++;
      if ({lat == 1, illegal, high, low} !== {2'b10, 32'h0, exp[i]}) begin
        bad++; $display("FAIL shift%0d got lat=%0d ill=%b high=%h low=%h want 1 0 00000000 %h",
                        i, lat, illegal, high, low, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_complement();
    logic [1:0] ops [2] = '{2'b00, 2'b01};
    logic [3:0] fns [2] = '{4'b0001, 4'b0011};
    int lat; bit rl;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], fns[i], 32'h12345678, 32'h80000002, lat, rl);
      total++;
      if ({lat == 1, illegal, high, low} !== {2'b10, 32'h0, 32'h7FFFFFFE}) begin
        bad++; $display("FAIL compl%0d got lat=%0d ill=%b high=%h low=%h want 1 0 00000000 7ffffffe",
                        i, lat, illegal, high, low);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [3:0] fns [4] = '{4'b0000, 4'b0101, 4'b0100, 4'b0001};
    int lat; bit rl;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], fns[i], 32'hDEADBEEF, 32'h00000005, lat, rl);
      total++;
      if ({lat == 1, illegal, high, low} !== {2'b11, 64'h0}) begin
        bad++; $display("FAIL illegal%0d got lat=%0d ill=%b high=%h low=%h want 1 1 0 0",
                        i, lat, illegal, high, low);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rl;
    issue(2'b00, 4'b0000, 32'd5, 32'd6, lat, rl);
    for (int i = 0; i < 5; i++) begin
      op_code = 2'b00; func_code = 4'b0000; a = 32'd100; b = 32'd200; in_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, high, low} !== {2'b10, 32'h0, 32'd11}) begin
        bad++; $display("FAIL hold%0d got vld=%b rdy=%b high=%h low=%h want 1 0 0 0000000b",
                        i, out_valid, in_ready, high, low);
      end
    end
    in_valid = 1'b0;
    consume();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL hold_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    issue(2'b00, 4'b0000, 32'd1, 32'd1, lat, rl);
    total++;
    if ({lat == 1, high, low} !== {1'b1, 32'h0, 32'd2}) begin
      bad++; $display("FAIL back_to_back got lat=%0d high=%h low=%h want 1 0 2", lat, high, low);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rl;
    int seen;
    op_code = 2'b01; func_code = 4'b0001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    total++;
    if ({out_valid, in_ready, illegal, high, low} !== {3'b010, 64'h0}) begin
      bad++; $display("FAIL rst_mid got vld=%b rdy=%b ill=%b high=%h low=%h want 0 1 0 0 0",
                      out_valid, in_ready, illegal, high, low);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_discard got %0d valid cycles want 0", seen); end
    issue(2'b00, 4'b0000, 32'd3, 32'd4, lat, rl);
    total++;
    if ({lat == 1, illegal, high, low} !== {2'b10, 32'h0, 32'd7}) begin
      bad++; $display("FAIL rst_then_add got lat=%0d ill=%b high=%h low=%h want 1 0 0 7", lat, illegal, high, low);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_unsigned();
    test_mul_signed();
    test_shifts();
    test_complement();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
